// File: rtl/zcache_pkg.sv
// ============================================================================
//  zcache_pkg : shared types and helpers for the associative Z80 read cache
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package zcache_pkg;

    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] idx_of(input logic [31:0] a, input int idx_w);
        return a & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a, input int idx_w);
        return a >> idx_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zcache_assoc_if.sv
// ============================================================================
//  zcache_assoc_if : CPU / DRAM-side signal bundle of the Z80 read cache
//  Revision        : 1.0
// ============================================================================
`default_nettype none

interface zcache_assoc_if #(
    parameter int ADDR_W = 21,
    parameter int WIN_N  = 4
);
    import zcache_pkg::*;

    localparam int WIN_W = (clog2(WIN_N) > 0) ? clog2(WIN_N) : 1;

    logic [ADDR_W-1:0] addr;
    logic [WIN_W-1:0]  win;
    logic [WIN_N-1:0]  win_en;
    logic              ram_acc;
    logic              wr_s;
    logic              wr_hi;
    logic [7:0]        wr_data;
    logic              fill_s;
    logic [15:0]       fill_data;
    logic              flush;
    logic              hit;
    logic [15:0]       rd_data;
    logic              busy;

    modport master (
        output addr, win, win_en, ram_acc, wr_s, wr_hi, wr_data,
               fill_s, fill_data, flush,
        input  hit, rd_data, busy
    );

    modport slave (
        input  addr, win, win_en, ram_acc, wr_s, wr_hi, wr_data,
               fill_s, fill_data, flush,
        output hit, rd_data, busy
    );

endinterface

`default_nettype wire

// File: rtl/zcache_way.sv
// ============================================================================
//  zcache_way : one cache way - {valid,tag} RAM, two byte-lane data RAMs,
//               registered valid/match/data read port
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module zcache_way #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 13
) (
    input  wire logic             clk,
    input  wire logic [IDX_W-1:0] raddr,
    input  wire logic [IDX_W-1:0] waddr,
    input  wire logic             tag_we,
    input  wire logic [TAG_W:0]   tag_wd,
    input  wire logic             lo_we,
    input  wire logic             hi_we,
    input  wire logic [7:0]       lo_wd,
    input  wire logic [7:0]       hi_wd,
    input  wire logic [TAG_W-1:0] tag_cmp,
    output logic                  valid,
    output logic                  match,
    output logic [15:0]           data
);
    localparam int SETS = 1 << IDX_W;

    logic [TAG_W:0] tag_ram [SETS];
    logic [7:0]     lo_ram  [SETS];
    logic [7:0]     hi_ram  [SETS];

    logic           same;
    logic [TAG_W:0] tag_nx;
    logic [7:0]     lo_nx;
    logic [7:0]     hi_nx;

    // Write-first read port: a line written this clk is visible on the next clk
    assign same   = (waddr == raddr);
    assign tag_nx = (tag_we && same) ? tag_wd : tag_ram[raddr];
    assign lo_nx  = (lo_we && same) ? lo_wd : lo_ram[raddr];
    assign hi_nx  = (hi_we && same) ? hi_wd : hi_ram[raddr];

    always_ff @(posedge clk) begin
        if (tag_we) tag_ram[waddr] <= tag_wd;
        if (lo_we)  lo_ram[waddr]  <= lo_wd;
        if (hi_we)  hi_ram[waddr]  <= hi_wd;
    end

    always_ff @(posedge clk) begin
        valid <= tag_nx[TAG_W];
        match <= tag_nx[TAG_W] && (tag_nx[TAG_W-1:0] == tag_cmp);
        data  <= {hi_nx, lo_nx};
    end

endmodule

`default_nettype wire

// File: rtl/zcache_assoc.sv
// ============================================================================
//  zcache_assoc : 1/2-way set-associative Z80 read cache with write update,
//                 LRU replacement and a set-by-set flush engine
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module zcache_assoc
    import zcache_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int IDX_W  = 8,
    parameter int WAYS   = 2,
    parameter int WIN_N  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    zcache_assoc_if.slave bus
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;
    localparam int WIN_W = (clog2(WIN_N) > 0) ? clog2(WIN_N) : 1;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [SETS-1:0]   lru;
    logic [ADDR_W-1:0] addr_d1;
    logic [WIN_W-1:0]  win_d1;
    logic              ram_acc_d1;

    logic [IDX_W-1:0]  idx_cur;
    logic [TAG_W-1:0]  tag_cur;
    logic [IDX_W-1:0]  idx_d1;
    logic [TAG_W-1:0]  tag_d1;

    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_match;
    logic [15:0]       way_data [WAYS];

    logic              any_match;
    logic              hit_w;
    logic              hit_way;
    logic              inv_found;
    logic              inv_way;
    logic              victim;
    logic              flushing;
    logic              run;
    logic              do_fill;
    logic              do_wr;
    logic [IDX_W-1:0]  waddr;
    logic [TAG_W:0]    tag_wd;
    logic [7:0]        lo_wd;
    logic [7:0]        hi_wd;

    assign idx_cur = IDX_W'(idx_of(32'(bus.addr), IDX_W));
    assign tag_cur = TAG_W'(tag_of(32'(bus.addr), IDX_W));
    assign idx_d1  = IDX_W'(idx_of(32'(addr_d1), IDX_W));
    assign tag_d1  = TAG_W'(tag_of(32'(addr_d1), IDX_W));

    assign any_match = |way_match;
    assign hit_w     = any_match && bus.win_en[win_d1] && ram_acc_d1 && (state == ST_RUN);

    always_comb begin
        hit_way   = 1'b0;
        inv_found = 1'b0;
        inv_way   = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) hit_way = 1'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = 1'(w);
            end
        end
        if (WAYS == 1)      victim = 1'b0;
        else if (any_match) victim = hit_way;
        else if (inv_found) victim = inv_way;
        else                victim = lru[idx_d1];
    end

    // A flush request outranks any fill or write arriving in the same clk
    assign flushing = (state == ST_FLUSH) && !rst;
    assign run      = (state == ST_RUN) && !bus.flush && !rst;
    assign do_fill  = run && bus.fill_s;
    assign do_wr    = run && bus.wr_s && !bus.fill_s && any_match;

    assign waddr  = flushing ? cnt : idx_d1;
    assign tag_wd = flushing ? '0 : {1'b1, tag_d1};
    assign lo_wd  = (bus.wr_s && !bus.wr_hi) ? bus.wr_data : bus.fill_data[7:0];
    assign hi_wd  = (bus.wr_s &&  bus.wr_hi) ? bus.wr_data : bus.fill_data[15:8];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic sel_fill;
        logic sel_wr;

        assign sel_fill = do_fill && (victim == 1'(g));
        assign sel_wr   = do_wr && (hit_way == 1'(g));

        zcache_way #(
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_way (
            .clk     (clk),
            .raddr   (idx_cur),
            .waddr   (waddr),
            .tag_we  (flushing || sel_fill),
            .tag_wd  (tag_wd),
            .lo_we   (sel_fill || (sel_wr && !bus.wr_hi)),
            .hi_we   (sel_fill || (sel_wr &&  bus.wr_hi)),
            .lo_wd   (lo_wd),
            .hi_wd   (hi_wd),
            .tag_cmp (tag_cur),
            .valid   (way_valid[g]),
            .match   (way_match[g]),
            .data    (way_data[g])
        );
    end

    assign bus.hit     = hit_w;
    assign bus.rd_data = hit_w ? way_data[hit_way] : 16'h0000;
    assign bus.busy    = (state == ST_FLUSH);

    always_ff @(posedge clk) begin
        addr_d1    <= bus.addr;
        win_d1     <= bus.win;
        ram_acc_d1 <= bus.ram_acc;
        if (rst) begin
            state <= ST_FLUSH;
            cnt   <= '0;
            lru   <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (bus.flush)       cnt   <= '0;
                    else if (&cnt)       state <= ST_RUN;
                    else                 cnt   <= cnt + 1'b1;
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state <= ST_FLUSH;
                        cnt   <= '0;
                    end else if (bus.fill_s) begin
                        lru[idx_d1] <= ~victim;
                    end else if (!bus.wr_s && hit_w) begin
                        lru[idx_d1] <= ~hit_way;
                    end
                end
                default: state <= ST_FLUSH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zcache_assoc.sv
// ============================================================================
//  tb_zcache_assoc : directed self-checking bench for zcache_assoc
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_zcache_assoc;

    localparam int ADDR_W = 21;
    localparam int IDX_W  = 8;
    localparam int WAYS   = 2;
    localparam int WIN_N  = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [16:0] exp_q [$];
    string       name_q [$];

    zcache_assoc_if #(.ADDR_W(ADDR_W), .WIN_N(WIN_N)) bus ();

    zcache_assoc #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .WAYS   (WAYS),
        .WIN_N  (WIN_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard: queue the expected {hit, rd_data}, let the read latency pass, then pop and compare
    task automatic expect_read(input string name, input logic [20:0] a,
                               input logic h, input logic [15:0] d);
        bus.addr = a;
        exp_q.push_back({h, d});
        name_q.push_back(name);
        tick(2);
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            cmp(name_q.pop_front(), {15'd0, bus.hit, bus.rd_data}, {15'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_fill(input logic [20:0] a, input logic [15:0] d);
        bus.addr = a;
        tick(2);
        bus.fill_s    = 1'b1;
        bus.fill_data = d;
        tick(1);
        bus.fill_s = 1'b0;
    endtask

    task automatic do_wr(input logic [20:0] a, input logic hi, input logic [7:0] d);
        bus.addr = a;
        tick(2);
        bus.wr_s    = 1'b1;
        bus.wr_hi   = hi;
        bus.wr_data = d;
        tick(1);
        bus.wr_s = 1'b0;
    endtask

    // Counts busy clocks from the current negedge; optionally hammers fill_s meanwhile
    task automatic measure_busy(input string name, input logic hammer);
        int   n;
        logic saw_hit;
        n       = 0;
        saw_hit = 1'b0;
        while (bus.busy === 1'b1 && n < 600) begin
            if (bus.hit !== 1'b0) saw_hit = 1'b1;
            bus.fill_s    = hammer;
            bus.fill_data = 16'h1234;
            n++;
            tick(1);
        end
        bus.fill_s = 1'b0;
        cmp({name, "_busy_clks"}, 32'(n), 32'd256);
        cmp({name, "_hit_during_flush"}, {31'd0, saw_hit}, 32'd0);
    endtask

    function automatic logic [20:0] set34(input logic [12:0] t);
        return {t, 8'h34};
    endfunction

    initial begin
        rst           = 1'b1;
        bus.addr      = 21'h0;
        bus.win       = 2'd1;
        bus.win_en    = 4'hF;
        bus.ram_acc   = 1'b1;
        bus.wr_s      = 1'b0;
        bus.wr_hi     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.fill_s    = 1'b0;
        bus.fill_data = 16'h0000;
        bus.flush     = 1'b0;

        // Reset and auto-flush, with fills hammered at a fixed address
        tick(1);
        rst = 1'b0;
        cmp("reset_busy", {31'd0, bus.busy}, 32'd1);
        cmp("reset_hit", {31'd0, bus.hit}, 32'd0);
        cmp("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);
        bus.addr = 21'h0A_1234;
        measure_busy("rst_flush", 1'b1);
        expect_read("fill_ignored_in_flush", 21'h0A_1234, 1'b0, 16'h0000);

        // Fill then read hit; window disable and ROM access mask the hit
        do_fill(21'h0A_1234, 16'hBEEF);
        expect_read("fill_hit", 21'h0A_1234, 1'b1, 16'hBEEF);
        bus.win_en = 4'b1101;
        expect_read("win_disabled", 21'h0A_1234, 1'b0, 16'h0000);
        bus.win_en = 4'hF;
        bus.ram_acc = 1'b0;
        expect_read("rom_access", 21'h0A_1234, 1'b0, 16'h0000);
        bus.ram_acc = 1'b1;

        // Write update of a cached line
        do_wr(21'h0A_1234, 1'b1, 8'h55);
        expect_read("wr_hi_update", 21'h0A_1234, 1'b1, 16'h55EF);
        do_wr(21'h0B_1234, 1'b0, 8'hAA);
        expect_read("wr_miss_not_alloc", 21'h0B_1234, 1'b0, 16'h0000);
        expect_read("wr_miss_no_change", 21'h0A_1234, 1'b1, 16'h55EF);
        bus.win_en = 4'b1101;
        do_wr(21'h0A_1234, 1'b0, 8'h66);
        bus.win_en = 4'hF;
        expect_read("wr_coherent_win_off", 21'h0A_1234, 1'b1, 16'h5566);

        // Fill and write in the same clk merge into one line
        bus.addr = 21'h05_0077;
        tick(2);
        bus.fill_s    = 1'b1;
        bus.fill_data = 16'h1234;
        bus.wr_s      = 1'b1;
        bus.wr_hi     = 1'b0;
        bus.wr_data   = 8'h99;
        tick(1);
        bus.fill_s = 1'b0;
        bus.wr_s   = 1'b0;
        expect_read("fill_wr_merge", 21'h05_0077, 1'b1, 16'h1299);

        // Flush in the same clk as a fill drops the fill and invalidates everything
        bus.addr = 21'h1F_0099;
        tick(2);
        bus.fill_s    = 1'b1;
        bus.fill_data = 16'hCAFE;
        bus.flush     = 1'b1;
        tick(1);
        bus.fill_s = 1'b0;
        bus.flush  = 1'b0;
        measure_busy("cmd_flush", 1'b0);
        expect_read("flush_drops_fill", 21'h1F_0099, 1'b0, 16'h0000);
        expect_read("flush_clears_a", 21'h0A_1234, 1'b0, 16'h0000);
        expect_read("flush_clears_d", 21'h05_0077, 1'b0, 16'h0000);

        // LRU: read hit on tag 1 between fills makes tag 2 the victim
        do_fill(set34(13'h01), 16'h0101);
        do_fill(set34(13'h02), 16'h0202);
        expect_read("lru_tag1_hit", set34(13'h01), 1'b1, 16'h0101);
        do_fill(set34(13'h03), 16'h0303);
        expect_read("lru_tag2_evicted", set34(13'h02), 1'b0, 16'h0000);
        expect_read("lru_tag1_kept", set34(13'h01), 1'b1, 16'h0101);
        expect_read("lru_tag3_hit", set34(13'h03), 1'b1, 16'h0303);

        // rst in the middle of a flush restarts from set 0
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        tick(100);
        cmp("midflush_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        measure_busy("midflush_rst", 1'b0);
        expect_read("midflush_clears", set34(13'h03), 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
